// File: rtl/pwm_capture_pkg.sv
// Shared types and default sizing for the PWM capture block.
package pwm_capture_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } state_e;

   localparam int DEF_CNT_W   = 16;
   localparam int DEF_TIMEOUT = 1000;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer plus a registered edge detector; rise/fall are
// single-cycle strobes three clocks after the asynchronous input moves.
module sync_edge (
   input  logic CLK,
   input  logic RST,
   input  logic d_async,
   output logic rise,
   output logic fall
);

   logic sync1_q;
   logic sync2_q;
   logic prev_q;
   logic rise_q;
   logic fall_q;

   // synchronizer, history flop and registered strobes
   always_ff @(posedge CLK) begin
      if (RST) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         sync1_q <= d_async;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         rise_q  <= sync2_q & ~prev_q;
         fall_q  <= ~sync2_q & prev_q;
      end
   end

   assign rise = rise_q;
   assign fall = fall_q;

endmodule

// File: rtl/pwm_capture.sv
// Measures period and high time of an asynchronous PWM/tach input, with
// saturation reporting and an edge-free stall detector.
module pwm_capture
   import pwm_capture_pkg::*;
#(
   parameter int CNT_W   = DEF_CNT_W,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             en,
   input  logic             pwm_in,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high_time,
   output logic             meas_valid,
   output logic             overflow,
   output logic             stalled
);

   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] TO_TC    = CNT_W'(TIMEOUT);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_ONE;
   endfunction

   logic             rise_s, fall_s;
   logic             stall_evt_s, start_s, publish_s, high_run_s;
   state_e           state_q, state_d;
   logic [CNT_W-1:0] per_cnt_q, per_cnt_d, high_cnt_q, high_cnt_d, to_cnt_q, to_cnt_d;
   logic [CNT_W-1:0] period_q, period_d, high_time_q, high_time_d;
   logic             meas_valid_q, meas_valid_d, overflow_q, overflow_d, stalled_q, stalled_d;

   sync_edge u_sync_edge (
      .CLK     (CLK),
      .RST     (RST),
      .d_async (pwm_in),
      .rise    (rise_s),
      .fall    (fall_s)
   );

   // A strobe landing on the terminal count wins over the stall.
   assign stall_evt_s = en && (to_cnt_q == TO_TC) && !rise_s && !fall_s;

   // FSM state register
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_d = state_q;
      if (!en) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    if (rise_s) state_d = HIGH; else state_d = IDLE;
            HIGH:    if (fall_s) state_d = LOW;  else if (stall_evt_s) state_d = IDLE; else state_d = HIGH;
            LOW:     if (rise_s) state_d = HIGH; else if (stall_evt_s) state_d = IDLE; else state_d = LOW;
            default: state_d = IDLE;
         endcase
      end
   end

   // FSM decoded controls
   always_comb begin
      start_s    = 1'b0;
      publish_s  = 1'b0;
      high_run_s = 1'b0;
      if (en) begin
         case (state_q)
            IDLE:    start_s = rise_s;
            HIGH:    high_run_s = !fall_s;
            LOW: begin
               start_s   = rise_s;
               publish_s = rise_s;
            end
            default: start_s = 1'b0;
         endcase
      end else begin
         start_s = 1'b0;
      end
   end

   // measurement and edge-free counters
   always_comb begin
      per_cnt_d  = sat_inc(per_cnt_q);
      high_cnt_d = high_cnt_q;
      to_cnt_d   = sat_inc(to_cnt_q);
      if (!en) begin
         per_cnt_d  = CNT_ZERO;
         high_cnt_d = CNT_ZERO;
         to_cnt_d   = CNT_ZERO;
      end else begin
         if (start_s) begin
            per_cnt_d  = CNT_ONE;
            high_cnt_d = CNT_ONE;
         end else if (high_run_s) begin
            high_cnt_d = sat_inc(high_cnt_q);
         end else begin
            high_cnt_d = high_cnt_q;
         end
         if (rise_s || fall_s) begin
            to_cnt_d = CNT_ZERO;
         end else if (to_cnt_q == TO_TC) begin
            to_cnt_d = to_cnt_q;
         end else begin
            to_cnt_d = sat_inc(to_cnt_q);
         end
      end
   end

   // result and status next-state
   always_comb begin
      period_d     = period_q;
      high_time_d  = high_time_q;
      overflow_d   = overflow_q;
      meas_valid_d = publish_s;
      stalled_d    = stalled_q;
      if (publish_s) begin
         period_d    = per_cnt_q;
         high_time_d = high_cnt_q;
         overflow_d  = (per_cnt_q == CNT_MAX) || (high_cnt_q == CNT_MAX);
      end else begin
         overflow_d  = overflow_q;
      end
      if (!en) begin
         stalled_d = stalled_q;
      end else if (rise_s) begin
         stalled_d = 1'b0;
      end else if (stall_evt_s) begin
         stalled_d = 1'b1;
      end else begin
         stalled_d = stalled_q;
      end
   end

   // counter and output registers
   always_ff @(posedge CLK) begin
      if (RST) begin
         per_cnt_q    <= CNT_ZERO;
         high_cnt_q   <= CNT_ZERO;
         to_cnt_q     <= CNT_ZERO;
         period_q     <= CNT_ZERO;
         high_time_q  <= CNT_ZERO;
         meas_valid_q <= 1'b0;
         overflow_q   <= 1'b0;
         stalled_q    <= 1'b0;
      end else begin
         per_cnt_q    <= per_cnt_d;
         high_cnt_q   <= high_cnt_d;
         to_cnt_q     <= to_cnt_d;
         period_q     <= period_d;
         high_time_q  <= high_time_d;
         meas_valid_q <= meas_valid_d;
         overflow_q   <= overflow_d;
         stalled_q    <= stalled_d;
      end
   end

   assign period     = period_q;
   assign high_time  = high_time_q;
   assign meas_valid = meas_valid_q;
   assign overflow   = overflow_q;
   assign stalled    = stalled_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: a 16-bit default instance and an 8-bit
// instance for saturation, checked against hand-computed values.
module tb_pwm_capture;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        en  = 1'b0;
   logic        pwm16 = 1'b0;
   logic        pwm8  = 1'b0;
   logic [15:0] per16, high16;
   logic        mv16, ovf16, st16;
   logic [7:0]  per8, high8;
   logic        mv8, ovf8, st8;

   int n_checks = 0;
   int n_err    = 0;
   int vcnt16 = 0, vcnt8 = 0, dbl16 = 0, dbl8 = 0;
   int lper16 = 0, lhigh16 = 0, lovf16 = 0;
   int lper8 = 0, lhigh8 = 0, lovf8 = 0;
   logic mv16_prev = 1'b0, mv8_prev = 1'b0;
   int v0, v1;

   always #5 CLK = ~CLK;

   pwm_capture dut (
      .CLK(CLK), .RST(RST), .en(en), .pwm_in(pwm16),
      .period(per16), .high_time(high16), .meas_valid(mv16),
      .overflow(ovf16), .stalled(st16)
   );

   pwm_capture #(.CNT_W(8), .TIMEOUT(250)) dut8 (
      .CLK(CLK), .RST(RST), .en(en), .pwm_in(pwm8),
      .period(per8), .high_time(high8), .meas_valid(mv8),
      .overflow(ovf8), .stalled(st8)
   );

   // record every valid pulse just after the clock edge
   always begin
      @(posedge CLK);
      #1;
      if (mv16) begin
         vcnt16++; lper16 = int'(per16); lhigh16 = int'(high16); lovf16 = int'(ovf16);
         if (mv16_prev) dbl16++;
      end
      if (mv8) begin
         vcnt8++; lper8 = int'(per8); lhigh8 = int'(high8); lovf8 = int'(ovf8);
         if (mv8_prev) dbl8++;
      end
      mv16_prev = mv16;
      mv8_prev  = mv8;
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge CLK);
   endtask

   task automatic drive(input bit sel8, input int hi, input int lo);
      if (sel8) pwm8 = 1'b1; else pwm16 = 1'b1;
      repeat (hi) tick();
      if (sel8) pwm8 = 1'b0; else pwm16 = 1'b0;
      repeat (lo) tick();
   endtask

   initial begin
      repeat (3) tick();
      check_val("rst_period",   32'(per16),  32'd0);
      check_val("rst_high",     32'(high16), 32'd0);
      check_val("rst_valid",    32'(mv16),   32'd0);
      check_val("rst_overflow", 32'(ovf16),  32'd0);
      check_val("rst_stalled",  32'(st16),   32'd0);
      RST = 1'b0;
      en  = 1'b1;

      // steady 40/60 stream: first rise only starts a measurement
      repeat (4) drive(1'b0, 40, 60);
      check_val("p40_count",  32'(vcnt16),  32'd3);
      check_val("p40_period", 32'(lper16),  32'd100);
      check_val("p40_high",   32'(lhigh16), 32'd40);
      check_val("p40_ovf",    32'(lovf16),  32'd0);

      // rise-to-valid latency is four clocks
      pwm16 = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         tick();
         check_val($sformatf("latency_k%0d", k), 32'(mv16), (k == 4) ? 32'd1 : 32'd0);
      end
      repeat (36) tick();
      pwm16 = 1'b0;
      repeat (60) tick();

      // duty change to 75/25
      drive(1'b0, 75, 25);
      check_val("duty_trans_count", 32'(vcnt16),  32'd5);
      check_val("duty_trans_high",  32'(lhigh16), 32'd40);
      drive(1'b0, 75, 25);
      check_val("duty_new_count",  32'(vcnt16),  32'd6);
      check_val("duty_new_period", 32'(lper16),  32'd100);
      check_val("duty_new_high",   32'(lhigh16), 32'd75);

      // held high: stall exactly TIMEOUT+1 cycles after the rise strobe
      pwm16 = 1'b1;
      repeat (1004) tick();
      check_val("stall_before_tc", 32'(st16), 32'd0);
      tick();
      check_val("stall_at_tc", 32'(st16), 32'd1);
      repeat (5) tick();
      check_val("stall_period", 32'(per16),  32'd100);
      check_val("stall_high",   32'(high16), 32'd75);
      check_val("stall_count",  32'(vcnt16), 32'd7);
      pwm16 = 1'b0;
      repeat (50) tick();
      check_val("stall_after_fall", 32'(st16), 32'd1);
      pwm16 = 1'b1;
      repeat (3) tick();
      check_val("stall_hold_k3", 32'(st16), 32'd1);
      tick();
      check_val("stall_clear_k4", 32'(st16), 32'd0);
      repeat (36) tick();
      pwm16 = 1'b0;
      repeat (60) tick();
      check_val("restart_no_valid", 32'(vcnt16), 32'd7);
      drive(1'b0, 40, 60);
      check_val("restart_count",  32'(vcnt16),  32'd8);
      check_val("restart_period", 32'(lper16),  32'd100);
      check_val("restart_high",   32'(lhigh16), 32'd40);

      // rise lands exactly on the timeout terminal count
      pwm16 = 1'b1;
      repeat (40) tick();
      pwm16 = 1'b0;
      repeat (1001) tick();
      drive(1'b0, 40, 60);
      check_val("tc_edge_count",   32'(vcnt16),  32'd10);
      check_val("tc_edge_period",  32'(lper16),  32'd1041);
      check_val("tc_edge_high",    32'(lhigh16), 32'd40);
      check_val("tc_edge_stalled", 32'(st16),    32'd0);

      // reset mid-HIGH
      pwm16 = 1'b1;
      repeat (10) tick();
      RST = 1'b1;
      tick();
      check_val("midrst_period",  32'(per16),  32'd0);
      check_val("midrst_high",    32'(high16), 32'd0);
      check_val("midrst_valid",   32'(mv16),   32'd0);
      check_val("midrst_ovf",     32'(ovf16),  32'd0);
      check_val("midrst_stalled", 32'(st16),   32'd0);
      RST = 1'b0;
      v0 = vcnt16;
      repeat (30) tick();
      pwm16 = 1'b0;
      repeat (60) tick();
      check_val("midrst_no_valid", 32'(vcnt16), 32'(v0));
      repeat (2) drive(1'b0, 40, 60);
      check_val("midrst_period2", 32'(lper16),  32'd100);
      check_val("midrst_high2",   32'(lhigh16), 32'd40);

      // enable dropped mid-LOW for five cycles
      pwm16 = 1'b1;
      repeat (40) tick();
      pwm16 = 1'b0;
      repeat (20) tick();
      v1 = vcnt16;
      en = 1'b0;
      repeat (5) tick();
      check_val("en0_period", 32'(per16),  32'd100);
      check_val("en0_high",   32'(high16), 32'd40);
      check_val("en0_valid",  32'(mv16),   32'd0);
      en = 1'b1;
      repeat (35) tick();
      drive(1'b0, 40, 60);
      check_val("en0_discard", 32'(vcnt16), 32'(v1));
      drive(1'b0, 40, 60);
      check_val("en0_resume_count",  32'(vcnt16),  32'(v1 + 1));
      check_val("en0_resume_period", 32'(lper16),  32'd100);
      check_val("en0_resume_high",   32'(lhigh16), 32'd40);

      // 8-bit saturation
      drive(1'b1, 100, 200);
      drive(1'b1, 100, 200);
      check_val("sat_count",  32'(vcnt8),  32'd1);
      check_val("sat_period", 32'(lper8),  32'd255);
      check_val("sat_high",   32'(lhigh8), 32'd100);
      check_val("sat_ovf",    32'(lovf8),  32'd1);
      drive(1'b1, 50, 150);
      check_val("sat2_ovf",   32'(lovf8),  32'd1);
      drive(1'b1, 50, 150);
      check_val("nosat_count",   32'(vcnt8),  32'd3);
      check_val("nosat_period",  32'(lper8),  32'd200);
      check_val("nosat_high",    32'(lhigh8), 32'd50);
      check_val("nosat_ovf",     32'(lovf8),  32'd0);
      check_val("nosat_stalled", 32'(st8),    32'd0);

      check_val("single_pulse16", 32'(dbl16), 32'd0);
      check_val("single_pulse8",  32'(dbl8),  32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 The module SHALL have parameter CNT_W, default 16, giving the width of the measurement counters and result outputs.
REQ-002 The module SHALL have parameter TIMEOUT, default 1000, giving the number of edge-free clock cycles that signals a stall; legal range is 2 to 2^CNT_W-1.
REQ-003 Port CLK, input, 1 bit: the single clock; all logic SHALL be clocked on its rising edge.
REQ-004 Port RST, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port en, input, 1 bit: measurement enable.
REQ-006 Port pwm_in, input, 1 bit: asynchronous PWM/tach waveform, for example the output of the team's flex counter/fan driver.
REQ-007 Port period, output, CNT_W bits: last measured period in CLK cycles.
REQ-008 Port high_time, output, CNT_W bits: last measured high duration in CLK cycles.
REQ-009 Port meas_valid, output, 1 bit: one-cycle pulse when period and high_time update.
REQ-010 Port overflow, output, 1 bit: the last measurement saturated.
REQ-011 Port stalled, output, 1 bit: no pwm_in edge has occurred for TIMEOUT cycles.

Function
REQ-012 pwm_in SHALL pass through a 2-flop synchronizer followed by a registered edge detector that produces single-cycle rise and fall strobes.
REQ-013 The FSM SHALL have three states.
- IDLE: wait for the first rise, then go to HIGH.
- HIGH: on fall, latch the high count and go to LOW.
- LOW: on rise, publish the result and go to HIGH.
REQ-014 The period count SHALL be 1 in the cycle after a rise strobe and SHALL increment by 1 each cycle until the next rise strobe; the high count SHALL follow the same rule, starting at rise and stopping at fall.
- Consequence: period equals the rise-to-rise spacing in CLK cycles.
- Consequence: high_time equals the rise-to-fall spacing in CLK cycles.
REQ-015 On a rise strobe in LOW, the block SHALL:
- load period and high_time in the next cycle;
- assert meas_valid for exactly that one cycle;
- set overflow if either count saturated during the measurement, and clear it otherwise.
REQ-016 Counters SHALL saturate at 2^CNT_W-1 and SHALL never wrap.
REQ-017 The first rise after IDLE SHALL only start a measurement; meas_valid SHALL NOT assert for the partial first period.
REQ-018 An edge-free counter SHALL be cleared by every rise or fall strobe.
- When it reaches TIMEOUT, the FSM SHALL go to IDLE and stalled SHALL be set.
- period and high_time SHALL hold their previous values.
REQ-019 stalled SHALL clear in the cycle after the next rise strobe.
REQ-020 If a rise strobe coincides with the timeout terminal count, the edge SHALL win: no stall, and normal LOW->HIGH handling applies.
REQ-021 When en=0, the FSM SHALL go to IDLE and the in-progress measurement SHALL be discarded.
- meas_valid SHALL stay 0.
- Outputs SHALL hold their values.
- The timeout counter SHALL be held at 0.
REQ-022 A fall strobe in IDLE or LOW, or a rise strobe in HIGH, SHALL be ignored (a glitch narrower than one cycle cannot produce both strobes).
REQ-023 Latency from a pwm_in rising edge to meas_valid SHALL be 4 CLK cycles (2 synchronizer + 1 edge register + 1 output register).

Reset
REQ-024 With RST=1 at a CLK edge, the following SHALL take these values: FSM=IDLE, synchronizer and edge flops=0, all counters=0, period=0, high_time=0, meas_valid=0, overflow=0, stalled=0.
REQ-025 RST SHALL take priority over en and over all strobes.
REQ-026 After RST is asserted mid-measurement, no meas_valid SHALL occur until two full rises have been seen following reset release.

Structure
REQ-027 Package pwm_capture_pkg SHALL hold the FSM state enum (IDLE, HIGH, LOW) and the default CNT_W and TIMEOUT constants.
REQ-028 The synchronizer and edge detector SHALL be a sub-module named sync_edge, with ports CLK, RST, d_async, rise and fall.
REQ-029 Counters, timeout logic and the FSM SHALL reside in pwm_capture.

Verification
REQ-030 en=1, pwm_in 40 cycles high / 60 low, repeated -> from the second rise onwards, meas_valid pulses once per 100 cycles with period=100 and high_time=40.
REQ-031 Duty changed to 75/25 mid-stream -> the first full new period reports period=100, high_time=75, with no spurious pulse at the transition.
REQ-032 pwm_in held high for 1000 cycles after a rise -> stalled=1 at timeout, period/high_time unchanged; next rise -> stalled=0, and valid returns after a further full period.
REQ-033 CNT_W=8, period 300 / high 100 -> period=255, high_time=100, overflow=1; then period 200 / high 50 -> overflow=0.
REQ-034 RST pulsed mid-HIGH, then en toggled low for 5 cycles mid-LOW -> all outputs 0 after RST, no meas_valid until two further rises, outputs held across en=0.
REQ-035 A rise timed to land exactly on the timeout terminal count -> stalled stays 0 and the period is reported normally.
